// File: rtl/sysarr_ctrl.sv
// sysarr_ctrl: sequences weight load, input streaming and output-valid tracking for an NxN weight-stationary systolic array
module sysarr_ctrl #(
  parameter int ARRAY_DIM = 16,
  parameter int VEC_BW = 16,
  parameter int OUT_LAT = 2*ARRAY_DIM-1,
  parameter int ROW_BW = $clog2(ARRAY_DIM)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [VEC_BW-1:0]    num_vec,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [ROW_BW-1:0]    w_row,
  output logic [ARRAY_DIM-1:0] we_rl,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 x_issue,
  output logic [VEC_BW-1:0]    x_idx,
  output logic                 out_valid,
  output logic [VEC_BW-1:0]    out_idx,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;
  state_t state, state_nxt;
  logic [VEC_BW-1:0] nv, vec_cnt, out_cnt;
  logic [ROW_BW-1:0] row_cnt;
  logic [OUT_LAT-1:0] dly;
  logic row_last, vec_last, out_last;
  assign row_last = row_cnt == ROW_BW'(ARRAY_DIM-1);
  assign vec_last = vec_cnt == nv - VEC_BW'(1);
  assign out_last = out_cnt == nv - VEC_BW'(1);
  always_ff @(posedge clk)
    state <= rstn ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD_W : IDLE;
      LOAD_W:  state_nxt = (w_valid && row_last) ? ((nv == '0) ? FIN : STREAM) : LOAD_W;
      STREAM:  state_nxt = (x_valid && vec_last) ? DRAIN : STREAM;
      DRAIN:   state_nxt = (out_valid && out_last) ? FIN : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_ready = state == LOAD_W;
    w_row = row_cnt;
    we_rl = (w_ready && w_valid) ? ARRAY_DIM'(1) << row_cnt : '0;
    x_ready = state == STREAM;
    x_issue = x_ready && x_valid;
    x_idx = vec_cnt;
    out_valid = dly[OUT_LAT-1];
    out_idx = out_cnt;
    busy = state != IDLE;
    done = state == FIN;
  end
  // the delay line shifts in every state so output k lands OUT_LAT cycles after its issue regardless of bubbles
  always_ff @(posedge clk) begin
    if (rstn) begin
      nv <= '0;
      vec_cnt <= '0;
      out_cnt <= '0;
      row_cnt <= '0;
      dly <= '0;
    end else begin
      dly <= {dly[OUT_LAT-2:0], x_issue};
      if (state == IDLE && start) begin
        nv <= num_vec;
        vec_cnt <= '0;
        out_cnt <= '0;
      end
      if (w_ready && w_valid) row_cnt <= row_last ? '0 : row_cnt + ROW_BW'(1);
      if (x_issue) vec_cnt <= vec_cnt + VEC_BW'(1);
      if (out_valid) out_cnt <= out_cnt + VEC_BW'(1);
    end
  end
endmodule

// File: tb/tb_sysarr_ctrl.sv
// tb_sysarr_ctrl: randomized bench for sysarr_ctrl checked against a job-level event model
module tb_sysarr_ctrl;
  localparam int AD = 16, VB = 16, OL = 2*AD-1, RB = $clog2(AD);
  logic clk = 0, rstn = 1, start = 0, w_valid = 0, x_valid = 0;
  logic [VB-1:0] num_vec = '0;
  logic w_ready, x_ready, x_issue, out_valid, busy, done;
  logic [RB-1:0] w_row;
  logic [AD-1:0] we_rl;
  logic [VB-1:0] x_idx, out_idx;
  always #5 clk = ~clk;
  sysarr_ctrl #(.ARRAY_DIM(AD), .VEC_BW(VB)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_vec(num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .we_rl(we_rl),
    .x_valid(x_valid), .x_ready(x_ready), .x_issue(x_issue), .x_idx(x_idx),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done)
  );
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // model: a job is 16 row loads, then nv issues, each producing an output OL cycles later
  bit act = 0, req = 0, xpat_on = 0;
  int rows = 0, nvm = 0, issued = 0, seen = 0, cyc = 0, done_at = -1;
  int oq[$], iq[$];
  bit xpat[$];
  int wp = 100, xp = 100, sp = 0;
  logic [VB-1:0] job_nv = '0;
  int ns, ni, no, nd;
  task automatic tick(input bit do_rst);
    bit ld, st, ov, dn, a0;
    @(negedge clk);
    a0 = act;
    ld = act && rows < AD;
    st = act && rows == AD && issued < nvm;
    ov = oq.size() > 0 && oq[0] == cyc;
    dn = cyc == done_at;
    rstn = do_rst;
    start = act ? ($urandom_range(99) < sp) : req;
    num_vec = act ? VB'($urandom) : job_nv;
    w_valid = $urandom_range(99) < wp;
    x_valid = (xpat_on && st && xpat.size() > 0) ? xpat.pop_front() : ($urandom_range(99) < xp);
    #1;
    if (do_rst) begin
      act = 0; rows = 0; done_at = -1;
      oq.delete(); iq.delete();
    end else begin
      chk("w_ready", w_ready, ld);
      chk("we_rl", 32'(we_rl), (ld && w_valid) ? 32'(1) << rows : 0);
      if (ld) chk("w_row", 32'(w_row), rows);
      chk("x_ready", x_ready, st);
      chk("x_issue", x_issue, st && x_valid);
      if (st) chk("x_idx", 32'(x_idx), issued);
      chk("out_valid", out_valid, ov);
      if (ov) chk("out_idx", 32'(out_idx), seen);
      chk("busy", busy, act);
      chk("done", done, dn);
      if (we_rl != 0) ns++;
      if (x_issue) begin ni++; iq.push_back(cyc); end
      if (out_valid) begin
        no++;
        if (iq.size() > 0) chk("latency", cyc - iq.pop_front(), OL);
        else chk("spurious_out", 1, 0);
      end
      if (done) nd++;
      if (ld && w_valid) begin
        rows++;
        if (rows == AD && nvm == 0) done_at = cyc + 1;
      end
      if (st && x_valid) begin issued++; oq.push_back(cyc + OL); end
      if (ov) begin
        void'(oq.pop_front());
        seen++;
        if (seen == nvm) done_at = cyc + 1;
      end
      if (dn) begin act = 0; done_at = -1; end
      if (!a0 && start) begin
        act = 1; nvm = int'(num_vec); rows = 0; issued = 0; seen = 0;
      end
    end
    cyc++;
  endtask
  task automatic launch(input int nv);
    job_nv = VB'(nv);
    ns = 0; ni = 0; no = 0; nd = 0;
    req = 1;
    tick(0);
    req = 0;
  endtask
  task automatic run_job(input int nv);
    int n;
    launch(nv);
    n = 0;
    while (act && n < 3000) begin tick(0); n++; end
    chk("job_timeout", act, 0);
    chk("n_strobe", ns, AD);
    chk("n_issue", ni, nv);
    chk("n_out", no, nv);
    chk("n_done", nd, 1);
    tick(0);
  endtask
  initial begin
    int n;
    tick(1);
    tick(1);
    tick(0);
    chk("rst_busy", busy, 0);
    chk("rst_w_row", 32'(w_row), 0);
    chk("rst_x_idx", 32'(x_idx), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_we_rl", 32'(we_rl), 0);
    wp = 100; xp = 100; sp = 0;
    run_job(4);
    wp = 50; xp = 100;
    run_job(2);
    wp = 100; xp = 0; xpat_on = 1;
    xpat = '{1, 0, 0, 1, 1};
    run_job(3);
    xpat_on = 0; xp = 100;
    run_job(0);
    sp = 100;
    run_job(3);
    sp = 0;
    launch(4);
    n = 0;
    while (!(act && rows == AD && issued == nvm && oq.size() == 2) && n < 500) begin tick(0); n++; end
    chk("drain_reach", n < 500, 1);
    tick(1);
    ns = 0; ni = 0; no = 0; nd = 0;
    for (int i = 0; i < 40; i++) tick(0);
    chk("post_rst_out", no, 0);
    chk("post_rst_done", nd, 0);
    run_job(2);
    for (int j = 0; j < 8; j++) begin
      wp = $urandom_range(30, 100);
      xp = $urandom_range(30, 100);
      sp = $urandom_range(0, 50);
      run_job($urandom_range(0, 6));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
